// File: rtl/trng_word_reader.sv
// trng_word_reader
//   Packs the corrected TRNG bit stream into WIDTH-bit words (first accepted bit
//   lands in the MSB). Buffers the words in a DEPTH-entry show-ahead FIFO and serves
//   them over a valid/ready read port.
//   Optional feature: define TRNG_RCT_EN to enable the repetition-count health test.
//   When it trips, rct_fail is set and collection halts in FAIL until en is dropped.
//   Without the macro, rct_fail is tied low and FAIL is unreachable.
//   Reset is asynchronous and active-low on rst.

module trng_word_reader #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RCT_CUTOFF = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     rct_fail
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_FW = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FAIL    = 2'd2
    } state_t;

    // collector state
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               push_q, push_d;

    // FIFO state
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0]  count_q, count_d;
    logic               rd_valid_q, rd_valid_d;
    logic               overflow_q, overflow_d;

    // health test result
    logic               rct_trip;
    logic               rct_fail_q;

    logic [WIDTH-1:0]   shift_nxt;
    logic               last_bit;
    logic               pop;
    logic               full;
    logic               fifo_write;

    assign shift_nxt = {shift_q[WIDTH-2:0], bit_in};
    assign last_bit  = (bit_cnt_q == CNT_W'(WIDTH - 1));

`ifdef TRNG_RCT_EN
    localparam int unsigned RCT_W = $clog2(RCT_CUTOFF + 1);

    logic [RCT_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic               last_q, last_d;
    logic               rct_fail_d;

    // Repetition counter over accepted bits; a zero count means no reference bit yet
    always_comb begin
        rep_cnt_d  = rep_cnt_q;
        last_d     = last_q;
        rct_trip   = 1'b0;
        rct_fail_d = rct_fail_q;
        if (state_q != ST_COLLECT || !en) begin
            rep_cnt_d = '0;
        end else if (bit_valid) begin
            last_d = bit_in;
            if (rep_cnt_q != '0 && bit_in == last_q) begin
                rep_cnt_d = rep_cnt_q + RCT_W'(1);
            end else begin
                rep_cnt_d = RCT_W'(1);
            end
            if (rep_cnt_d >= RCT_W'(RCT_CUTOFF)) begin
                rct_trip = 1'b1;
            end
        end
        // en low forces IDLE on the same edge, so clearing on !en matches entry to IDLE
        if (rct_trip) begin
            rct_fail_d = 1'b1;
        end else if (!en) begin
            rct_fail_d = 1'b0;
        end
    end

    // Health test registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_cnt_q  <= '0;
            last_q     <= 1'b0;
            rct_fail_q <= 1'b0;
        end else begin
            rep_cnt_q  <= rep_cnt_d;
            last_q     <= last_d;
            rct_fail_q <= rct_fail_d;
        end
    end
`else
    assign rct_trip   = 1'b0;
    assign rct_fail_q = 1'b0;
`endif

    // Collector FSM: shifts accepted bits, emits a completed word as a one-cycle push
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        word_d    = word_q;
        push_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                shift_d   = '0;
                bit_cnt_d = '0;
                if (en) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (!en) begin
                    state_d   = ST_IDLE;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end else if (rct_trip) begin
                    state_d   = ST_FAIL;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end else if (bit_valid) begin
                    shift_d = shift_nxt;
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        word_d    = shift_nxt;
                        push_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FAIL: begin
                shift_d   = '0;
                bit_cnt_d = '0;
                if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                shift_d   = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Collector registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            word_q    <= '0;
            push_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            word_q    <= word_d;
            push_q    <= push_d;
        end
    end

    assign full       = (count_q == CNT_FW'(DEPTH));
    assign pop        = rd_valid_q && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign fifo_write = push_q && (!full || pop);

    // FIFO bookkeeping: pointers, occupancy, sticky overflow
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (fifo_write) begin
            mem_d[wr_ptr_q] = word_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({fifo_write, pop})
            2'b10:   count_d = count_q + CNT_FW'(1);
            2'b01:   count_d = count_q - CNT_FW'(1);
            default: count_d = count_q;
        endcase
        if (push_q && full && !pop) begin
            overflow_d = 1'b1;
        end
        rd_valid_d = (count_d != '0);
    end

    // FIFO registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign rd_data    = mem_q[rd_ptr_q];
    assign rd_valid   = rd_valid_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign rct_fail   = rct_fail_q;

endmodule

// File: tb/tb_trng_word_reader.sv
// Directed self-checking bench for trng_word_reader (WIDTH=32, DEPTH=4, RCT_CUTOFF=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_trng_word_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        rct_fail;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    trng_word_reader #(
        .WIDTH(32),
        .DEPTH(4),
        .RCT_CUTOFF(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .rd_ready(rd_ready),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .rct_fail(rct_fail)
    );

    // Sends v[n-1] down to v[0] on consecutive cycles; returns at the falling edge after the last bit is sampled
    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            bit_in    = v[i];
            bit_valid = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // One-cycle read handshake, called at a falling edge
    task automatic pop_one();
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00000000", rd_data); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (rct_fail !== 1'b0) begin n_fail++; $display("FAIL reset_rct_fail: got %b expected 0", rct_fail); end
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
    endtask

    task automatic test_reset_midstream();
        logic [31:0] w;
        w = 32'h3333_3333;
        send_bits(32'h0F0F_0F0F, 32);
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 1", fifo_count); end
        n_checks++; if (rd_data !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL mid_pre_data: got %h expected 0f0f0f0f", rd_data); end
        send_bits(32'h2AA, 10);
        #2 rst = 1'b0;
        #1;
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d expected 0", fifo_count); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rd_valid: got %b expected 0", rd_valid); end
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_rd_data: got %h expected 00000000", rd_data); end
        @(negedge clk);
        rst = 1'b1;
        send_bits(w >> 1, 31);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_31bits_rd_valid: got %b expected 0", rd_valid); end
        send_bits(32'h1, 1);
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL mid_word_rd_valid: got %b expected 1", rd_valid); end
        n_checks++; if (rd_data !== 32'h3333_3333) begin n_fail++; $display("FAIL mid_word_data: got %h expected 33333333", rd_data); end
        pop_one();
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_pop_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_word();
        send_bits(32'hAAAA_AAAA, 32);
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL word_early_rd_valid: got %b expected 0", rd_valid); end
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL word_rd_valid: got %b expected 1", rd_valid); end
        n_checks++; if (rd_data !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL word_data: got %h expected aaaaaaaa", rd_data); end
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL word_count: got %0d expected 1", fifo_count); end
        pop_one();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL word_pop_rd_valid: got %b expected 0", rd_valid); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL word_pop_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_overflow();
        logic [31:0] w [5];
        w = '{32'h1357_9BDF, 32'h2468_ACE0, 32'h5A5A_5A5A, 32'hC3C3_C3C3, 32'h9696_9696};
        for (int i = 0; i < 4; i++) send_bits(w[i], 32);
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_full_count: got %0d expected 4", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b expected 0", overflow); end
        send_bits(w[4], 32);
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_after_count: got %0d expected 4", fifo_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after: got %b expected 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rd_data !== w[i]) begin n_fail++; $display("FAIL ovf_drain_%0d: got %h expected %h", i, rd_data, w[i]); end
            pop_one();
        end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL ovf_drained_count: got %0d expected 0", fifo_count); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_rd_valid: got %b expected 0", rd_valid); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] w [5];
        w = '{32'h8421_8421, 32'h3C3C_3C3C, 32'h6969_6969, 32'hE1E1_E1E1, 32'h1717_1717};
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_reset_overflow: got %b expected 0", overflow); end
        for (int i = 0; i < 4; i++) send_bits(w[i], 32);
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL pp_full_count: got %0d expected 4", fifo_count); end
        send_bits(w[4], 32);
        pop_one();
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL pp_count: got %0d expected 4", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
        for (int i = 1; i < 5; i++) begin
            n_checks++; if (rd_data !== w[i]) begin n_fail++; $display("FAIL pp_drain_%0d: got %h expected %h", i, rd_data, w[i]); end
            pop_one();
        end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL pp_drained_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_en_drop();
        send_bits(32'h000A_BCDE, 20);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL endrop_count: got %0d expected 0", fifo_count); end
        en = 1'b1;
        send_bits(32'h1234_5678, 32);
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL endrop_rd_valid: got %b expected 1", rd_valid); end
        n_checks++; if (rd_data !== 32'h1234_5678) begin n_fail++; $display("FAIL endrop_data: got %h expected 12345678", rd_data); end
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL endrop_word_count: got %0d expected 1", fifo_count); end
        pop_one();
    endtask

    task automatic test_rct();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        send_bits(32'h7FFF, 15);
        n_checks++; if (rct_fail !== 1'b0) begin n_fail++; $display("FAIL rct_15_ones: got %b expected 0", rct_fail); end
        send_bits(32'h1, 1);
`ifdef TRNG_RCT_EN
        n_checks++; if (rct_fail !== 1'b1) begin n_fail++; $display("FAIL rct_16_ones: got %b expected 1", rct_fail); end
        send_bits(32'h0000, 16);
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rct_no_word_count: got %0d expected 0", fifo_count); end
        n_checks++; if (rct_fail !== 1'b1) begin n_fail++; $display("FAIL rct_held: got %b expected 1", rct_fail); end
`else
        n_checks++; if (rct_fail !== 1'b0) begin n_fail++; $display("FAIL rct_off_16_ones: got %b expected 0", rct_fail); end
        send_bits(32'h0000, 16);
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL rct_off_count: got %0d expected 1", fifo_count); end
        n_checks++; if (rd_data !== 32'hFFFF_0000) begin n_fail++; $display("FAIL rct_off_data: got %h expected ffff0000", rd_data); end
        pop_one();
`endif
        en = 1'b0;
        @(negedge clk);
        n_checks++; if (rct_fail !== 1'b0) begin n_fail++; $display("FAIL rct_cleared: got %b expected 0", rct_fail); end
        en = 1'b1;
        send_bits(32'h5A5A_5A5A, 32);
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL rct_resume_count: got %0d expected 1", fifo_count); end
        n_checks++; if (rd_data !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL rct_resume_data: got %h expected 5a5a5a5a", rd_data); end
        pop_one();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_reset_midstream();
        test_word();
        test_overflow();
        test_full_push_pop();
        test_en_drop();
        test_rct();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the end of the sequence");
        $fatal(1);
    end

endmodule
